// File: rtl/piano_key_tone_if.sv
// piano_key_tone_if: touch-sensor inputs, tone enable and note outputs of the piano tone block
interface piano_key_tone_if;
  logic [7:0] sensor_data1;
  logic [7:0] sensor_data2;
  logic tone_en;
  logic key_valid;
  logic [3:0] key_idx;
  logic key_event;
  logic beep_out;
  modport master(output sensor_data1, sensor_data2, tone_en, input key_valid, key_idx, key_event, beep_out);
  modport slave(input sensor_data1, sensor_data2, tone_en, output key_valid, key_idx, key_event, beep_out);
endinterface

// File: rtl/piano_key_tone.sv
// piano_key_tone: debounces 16 touch keys, selects the highest pressed one and plays its note
module piano_key_tone #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int SAMPLE_DIV = 120_000,
  parameter int DEB_SAMPLES = 3
) (
  input logic clk_in,
  input logic rst_n_in,
  piano_key_tone_if.slave bus
);
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int FREQ [16] = '{262, 294, 330, 349, 392, 440, 494, 523,
                               587, 659, 698, 784, 880, 988, 1047, 1175};
  typedef enum logic {SILENT, PLAY} state_t;
  logic [15:0] s1, s2, deb;
  logic [15:0][1:0] cnt;
  logic [SW-1:0] sc;
  logic tick;
  logic [15:0] hp_tab [16];
  logic [3:0] hi_idx, prev_idx;
  logic prev_valid;
  state_t state, state_n;
  logic [15:0] hp, hp_n, tc, tc_n;
  logic beep_n;
  for (genvar i = 0; i < 16; i++) begin : g_hp
    assign hp_tab[i] = 16'(CLK_FREQ / (2 * FREQ[i]));
  end
  assign tick = sc == SW'(SAMPLE_DIV - 1);
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      s1 <= '0;
      s2 <= '0;
      sc <= '0;
    end else begin
      s1 <= {bus.sensor_data2, bus.sensor_data1};
      s2 <= s1;
      sc <= tick ? '0 : sc + 1'b1;
    end
  // a key flips only after DEB_SAMPLES consecutive ticks disagreeing with its debounced state
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      deb <= '0;
      cnt <= '0;
    end else if (tick) begin
      for (int k = 0; k < 16; k++)
        if (s2[k] == deb[k]) cnt[k] <= '0;
        else if (cnt[k] == 2'(DEB_SAMPLES - 1)) begin
          deb[k] <= s2[k];
          cnt[k] <= '0;
        end else cnt[k] <= cnt[k] + 2'd1;
    end
  always_comb begin
    hi_idx = '0;
    for (int k = 0; k < 16; k++) if (deb[k]) hi_idx = 4'(k);
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      bus.key_valid <= 1'b0;
      bus.key_idx <= '0;
      bus.key_event <= 1'b0;
      prev_valid <= 1'b0;
      prev_idx <= '0;
    end else begin
      bus.key_valid <= |deb;
      bus.key_idx <= |deb ? hi_idx : bus.key_idx;
      prev_valid <= bus.key_valid;
      prev_idx <= bus.key_idx;
      bus.key_event <= bus.key_valid & (!prev_valid | (bus.key_idx != prev_idx));
    end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= SILENT;
      hp <= '0;
      tc <= '0;
      bus.beep_out <= 1'b0;
    end else begin
      state <= state_n;
      hp <= hp_n;
      tc <= tc_n;
      bus.beep_out <= beep_n;
    end
  // exit outranks a note change; a note change restarts the wave low
  always_comb begin
    state_n = state;
    hp_n = hp;
    tc_n = tc;
    beep_n = bus.beep_out;
    if (state == SILENT) begin
      tc_n = '0;
      beep_n = 1'b0;
      if (bus.key_valid && bus.tone_en) begin
        state_n = PLAY;
        hp_n = hp_tab[bus.key_idx];
      end
    end else if (!bus.key_valid || !bus.tone_en) begin
      state_n = SILENT;
      tc_n = '0;
      beep_n = 1'b0;
    end else if (bus.key_event) begin
      hp_n = hp_tab[bus.key_idx];
      tc_n = '0;
      beep_n = 1'b0;
    end else if (tc == hp - 16'd1) begin
      tc_n = '0;
      beep_n = !bus.beep_out;
    end else tc_n = tc + 16'd1;
  end
endmodule

// File: doc/piano_key_tone.md
Name: piano_key_tone

Overview:
- Sits directly downstream of the CAP1188 I2C reader on the Piano Shield.
- Takes the two 8-bit touch-status bytes (16 keys), synchronises and debounces them, and picks the highest pressed key.
- Drives the piezo buzzer with a square wave at that key's note frequency.
- Also exports the selected key index and a one-cycle note-on event for LEDs and the display.

Parameters:
- CLK_FREQ, 12_000_000, system clock frequency in Hz. Must keep the C4 half-period ≤ 65535.
- SAMPLE_DIV, 120_000, clock cycles per debounce sample tick (10 ms at 12 MHz). Must be ≥ 2.
- DEB_SAMPLES, 3, consecutive differing ticks needed to flip a key's debounced state. Range 1..4.

Ports:
- clk_in, input, 1, system clock.
- rst_n_in, input, 1, asynchronous active-low reset.
- sensor_data1, input, 8, touch status for keys 0..7 (bit k = key k). Not synchronous to clk_in.
- sensor_data2, input, 8, touch status for keys 8..15 (bit k = key k+8). Not synchronous to clk_in.
- tone_en, input, 1, 1 = buzzer allowed to sound. 0 = beep_out forced low (selection logic still runs).
- key_valid, output, 1, at least one debounced key is pressed.
- key_idx, output, 4, index of the selected key. Holds its last value when key_valid = 0.
- key_event, output, 1, one-cycle pulse on note-on or note change.
- beep_out, output, 1, square wave to the buzzer.

Behaviour:
- Clock and reset: one clock, clk_in; reset rst_n_in, asynchronous and active-low. All state is cleared on reset.
- Reset values: key_valid = 0, key_idx = 0, key_event = 0, beep_out = 0. Sample counter, sync flops, debounce counters, debounced key state, half-period register and tone counter are all 0.
- Synchroniser:
  - raw = {sensor_data2, sensor_data1}, passed through a 2-flop synchroniser on clk_in.
  - Multi-bit incoherence is absorbed by the debounce.
- Sample tick:
  - The counter runs 0..SAMPLE_DIV-1 and wraps.
  - tick is high for one cycle when the counter = SAMPLE_DIV-1.
- Debounce, per key k, evaluated only on tick:
  - If sync[k] == deb[k], cnt[k] ← 0.
  - Otherwise, if cnt[k] == DEB_SAMPLES-1, deb[k] ← sync[k] and cnt[k] ← 0.
  - Otherwise, cnt[k] ← cnt[k]+1.
  - A press or release therefore needs DEB_SAMPLES consecutive ticks. Shorter glitches are ignored.
- Selection, registered one cycle after deb updates:
  - key_valid = |deb.
  - key_idx = highest set index in deb (highest pitch wins).
  - If no key is set, key_idx holds its last value.
- key_event: one cycle high, in the cycle after the selection register updates, when either:
  - key_valid rises; or
  - key_valid stays 1 and key_idx changes.
  - A release to no keys produces no event.
- Note table: fixed 16 entries; half-period HP[i] = floor(CLK_FREQ / (2·f_i)), 16-bit. Frequencies in Hz:
  - Keys 0..7: C4 262, D4 294, E4 330, F4 349, G4 392, A4 440, B4 494, C5 523.
  - Keys 8..15: D5 587, E5 659, F5 698, G5 784, A5 880, B5 988, C6 1047, D6 1175.
- Tone FSM, states SILENT and PLAY:
  - SILENT: beep_out = 0, tone counter = 0.
    - Goes to PLAY when key_valid & tone_en; loads hp ← HP[key_idx], counter ← 0.
  - PLAY: counter increments each cycle.
    - When counter == hp-1: beep_out toggles and counter ← 0.
    - First rising edge of beep_out occurs hp cycles after entry. Period = 2·hp cycles.
  - PLAY → SILENT when key_valid = 0 or tone_en = 0; beep_out ← 0 in the same cycle.
  - On key_event while in PLAY: hp reloads, counter ← 0, beep_out ← 0, so the new note starts phase-clean.
  - Simultaneous key_event and exit condition: exit wins.
- Boundaries:
  - All 16 keys pressed → key_idx = 15.
  - Key held across the sample-counter wrap → no effect.
  - Reset asserted mid-note → beep_out goes low asynchronously. After release, the FSM restarts in SILENT and presses need full debounce again.
- Latency from a stable raw change to key_valid/key_idx: 2 sync cycles + up to DEB_SAMPLES ticks (the first of them partial) + 1 cycle. With defaults, ≤ 30 ms + 3 cycles.

Test Plan:
- Reset with inputs all 0 → all outputs 0. Hold 1 ms → beep_out stays 0 and key_event never pulses.
- SAMPLE_DIV=4, DEB_SAMPLES=3, sensor_data1=8'h20 held (key 5, A4) → key_valid=1 and key_idx=5 within 2+12+1 cycles, with one key_event. beep_out period = 27272 cycles (hp=13636).
- Same bench: key 5 pulsed for exactly 2 ticks, then released → key_valid stays 0, no key_event, beep_out = 0.
- Key 0 held, then sensor_data2=8'h80 added (key 15) → key_idx 0→15, one key_event, hp = 5106, beep_out restarts low. Release key 15 → key_idx=0 and a key_event.
- Key 3 held with tone_en toggled 1→0→1 → beep_out low while tone_en=0 and resumes from phase 0 (hp=17191). key_valid stays 1 throughout, no key_event.
- rst_n_in pulled low mid-note with key 10 held → beep_out=0 immediately. After release, key_valid returns only after full debounce, with one key_event.
